// File: rtl/mio_bus.sv
// Memory/IO bus controller: decodes core requests to external block RAM or
// on-chip peripherals (switches, LEDs, 7-segment register, down-counting timer).
module mio_bus (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_from_cpu,
  output logic [31:0] Data_to_cpu,
  output logic        MIO_ready,
  output logic        INT,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] seg_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Peripheral slots: 0 = seg, 1 = sw/led, 2 = timer, 3 = control
  localparam int NUM_PERIPH = 4;
  localparam logic [NUM_PERIPH-1:0][31:0] PERIPH_ADDR = {
    32'hF000_0008, 32'hF000_0004, 32'hF000_0000, 32'hE000_0000
  };
  localparam int SLOT_SEG   = 0;
  localparam int SLOT_IO    = 1;
  localparam int SLOT_TIMER = 2;
  localparam int SLOT_CTRL  = 3;

  state_t state_reg, state_next;

  logic [31:0] resp_reg, resp_next;
  logic [15:0] led_reg, led_next;
  logic [31:0] seg_reg, seg_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] reload_reg, reload_next;
  logic        cnt_en_reg, cnt_en_next;
  logic        int_en_reg, int_en_next;
  logic        irq_pending_reg, irq_pending_next;

  logic                  ram_hit;
  logic [NUM_PERIPH-1:0] periph_hit;
  logic                  req_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  expire;
  logic [31:0]           periph_rdata;
  logic                  unused_addr_bits;

  // Byte-lane bits never take part in decoding
  assign unused_addr_bits = ^Addr_in[1:0];

  assign ram_hit = (Addr_in[31:12] == 20'h0_0000);

  generate
    for (genvar gi = 0; gi < NUM_PERIPH; gi++) begin : g_decode
      assign periph_hit[gi] = (Addr_in[31:2] == PERIPH_ADDR[gi][31:2]);
    end
  endgenerate

  assign req_fire = (state_reg == IDLE) && CPU_MIO;
  assign wr_fire  = req_fire && mem_w;
  assign rd_fire  = req_fire && !mem_w;
  assign expire   = cnt_en_reg && (count_reg == 32'd0);

  // RAM port; reset gating keeps a held request from writing while in reset
  assign ram_addr = Addr_in[11:2];
  assign ram_din  = Data_from_cpu;
  assign ram_we   = wr_fire && ram_hit && !reset;

  assign MIO_ready   = (state_reg == DONE);
  assign Data_to_cpu = MIO_ready ? resp_reg : 32'd0;
  assign INT         = irq_pending_reg && int_en_reg;
  assign led         = led_reg;
  assign seg_data    = seg_reg;

  always_comb begin
    periph_rdata = 32'd0;
    if (periph_hit[SLOT_SEG]) begin
      periph_rdata = seg_reg;
    end else if (periph_hit[SLOT_IO]) begin
      periph_rdata = {16'd0, sw};
    end else if (periph_hit[SLOT_TIMER]) begin
      periph_rdata = count_reg;
    end else if (periph_hit[SLOT_CTRL]) begin
      periph_rdata = {29'd0, irq_pending_reg, int_en_reg, cnt_en_reg};
    end
  end

  always_comb begin
    state_next = state_reg;
    resp_next  = resp_reg;
    case (state_reg)
      IDLE: begin
        if (CPU_MIO) begin
          if (!mem_w && ram_hit) begin
            state_next = RD_WAIT;
          end else begin
            state_next = DONE;
            resp_next  = rd_fire ? periph_rdata : 32'd0;
          end
        end
      end
      RD_WAIT: begin
        state_next = DONE;
        resp_next  = ram_dout;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    led_next         = led_reg;
    seg_next         = seg_reg;
    count_next       = count_reg;
    reload_next      = reload_reg;
    cnt_en_next      = cnt_en_reg;
    int_en_next      = int_en_reg;
    irq_pending_next = irq_pending_reg;

    if (cnt_en_reg) begin
      count_next = expire ? reload_reg : count_reg - 32'd1;
    end

    if (wr_fire) begin
      if (periph_hit[SLOT_SEG]) begin
        seg_next = Data_from_cpu;
      end
      if (periph_hit[SLOT_IO]) begin
        led_next = Data_from_cpu[15:0];
      end
      // A CPU timer write overrides the reload that expiry would do
      if (periph_hit[SLOT_TIMER]) begin
        count_next  = Data_from_cpu;
        reload_next = Data_from_cpu;
      end
      if (periph_hit[SLOT_CTRL]) begin
        cnt_en_next = Data_from_cpu[0];
        int_en_next = Data_from_cpu[1];
        if (Data_from_cpu[2]) begin
          irq_pending_next = 1'b0;
        end
      end
    end

    // Expiry takes priority over a clear in the same cycle
    if (expire) begin
      irq_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      resp_reg        <= 32'd0;
      led_reg         <= 16'd0;
      seg_reg         <= 32'd0;
      count_reg       <= 32'd0;
      reload_reg      <= 32'd0;
      cnt_en_reg      <= 1'b0;
      int_en_reg      <= 1'b0;
      irq_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      resp_reg        <= resp_next;
      led_reg         <= led_next;
      seg_reg         <= seg_next;
      count_reg       <= count_next;
      reload_reg      <= reload_next;
      cnt_en_reg      <= cnt_en_next;
      int_en_reg      <= int_en_next;
      irq_pending_reg <= irq_pending_next;
    end
  end

endmodule

// File: doc/mio_bus.md
# mio_bus

Memory/IO bus controller sitting directly downstream of the multi-cycle CPU core. It accepts the core's memory requests, decodes the address to on-chip block RAM or memory-mapped peripherals, and returns read data with a `MIO_ready` handshake. Peripherals are a switch input port, an LED register, a 7-segment display register and a down-counting timer. The timer drives the core's `INT` input.

## Interface
- No parameters. RAM depth is fixed at 1024 words; the RAM is word-addressed.
- `clk` in 1: system clock. Everything is on the rising edge.
- `reset` in 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `CPU_MIO` in 1: request valid from the core. Address, data and `mem_w` are stable while it is high.
- `mem_w` in 1: 1 = write, 0 = read.
- `Addr_in` in 32: byte address from the core. Bits [1:0] are ignored.
- `Data_from_cpu` in 32: write data.
- `Data_to_cpu` out 32: read data. Valid only while `MIO_ready`=1; 0 otherwise.
- `MIO_ready` out 1: one-cycle completion pulse.
- `INT` out 1: level interrupt, equal to `irq_pending & int_en`.
- `ram_addr` out 10: RAM word address, `Addr_in[11:2]`.
- `ram_we` out 1: RAM write enable.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: RAM read data, valid one cycle after the address is presented (synchronous read).
- `sw` in 16: switch inputs.
- `led` out 16: LED register.
- `seg_data` out 32: 7-segment display register.

## Operation
Address map (full 32-bit compare except the RAM range):
- 0x0000_0000–0x0000_0FFF: RAM.
- 0xE000_0000: `seg_data`, read/write.
- 0xF000_0000: read returns {16'b0, `sw`}; write sets `led` <= `Data_from_cpu[15:0]`.
- 0xF000_0004: timer.
  - Read returns the current count.
  - Write sets reload <= data and count <= data.
- 0xF000_0008: control.
  - Bit0 = `cnt_en`, bit1 = `int_en`.
  - Writing bit2=1 clears `irq_pending`; bit2 is not stored.
  - Read returns {29'b0, `irq_pending`, `int_en`, `cnt_en`}.
- Any other address: read returns 0, write is ignored, and the access still completes.

FSM states: IDLE, RD_WAIT, DONE.
- IDLE & `CPU_MIO`=1:
  - RAM read → RD_WAIT.
  - All other accesses → DONE.
  - Writes (RAM or peripheral) commit at the edge that leaves IDLE.
- RD_WAIT → DONE. `ram_dout` is captured into the response register.
- DONE: `MIO_ready`=1 and `Data_to_cpu` = response. Unconditionally → IDLE.
- `CPU_MIO` is sampled only in IDLE. A request still high in the cycle after DONE is treated as a new request.

RAM port:
- `ram_addr` = `Addr_in[11:2]` (combinational).
- `ram_we` = IDLE & `CPU_MIO` & `mem_w` & RAM hit.
- `ram_din` = `Data_from_cpu`.

Timer (runs every cycle, independent of the FSM), when `cnt_en`=1:
- If count == 0: count <= reload and `irq_pending` <= 1.
- Else: count <= count − 1.
- Arithmetic is 32-bit unsigned. Reload 0 with `cnt_en`=1 sets pending every cycle.
- `cnt_en`=0 holds the count.

Simultaneous events:
- CPU write to 0xF000_0004 in the same cycle as expiry: the written value wins for count and reload, and pending is still set.
- Clear-pending write in the same cycle as expiry: set wins, so pending stays 1.

## Timing
- Non-RAM-read access: request seen in IDLE cycle N, `MIO_ready` in cycle N+1 (latency 1).
- RAM read: `MIO_ready` in cycle N+2 (latency 2).
- Minimum request spacing is 2 cycles (write/peripheral) or 3 cycles (RAM read).
- A read of 0xF000_0004 returns the count value present in cycle N, before that edge's decrement.
- Reset, asynchronous and effective immediately:
  - FSM goes to IDLE.
  - `MIO_ready`, `Data_to_cpu`, `INT`, `led`, `seg_data` = 0.
  - count, reload, `cnt_en`, `int_en`, `irq_pending` = 0.
  - `ram_we` = 0.
- Reset during RD_WAIT or DONE aborts the access; no `MIO_ready` pulse follows.
- `INT` is registered-state derived (no combinational path from CPU inputs). It goes high one cycle after the expiry edge when `int_en`=1.

## Test plan
- RAM write then read:
  - Write 0x0000_0010 ← 0xDEADBEEF: `ram_we`=1 for 1 cycle with `ram_addr`=4, and `MIO_ready` 1 cycle later.
  - Read 0x0000_0010: `MIO_ready` 2 cycles after the request, with `Data_to_cpu`=0xDEADBEEF.
- Peripherals:
  - Write 0xF000_0000 ← 0x1234_ABCD: `led`=0xABCD.
  - With `sw`=0x00F0, read 0xF000_0000: returns 0x0000_00F0.
  - Write 0xE000_0000 ← 0x8765_4321, then read it back: returns 0x8765_4321.
- Timer interrupt:
  - Write timer=3, then ctrl=0x3.
  - `INT` rises 4 cycles after `cnt_en` takes effect; count reloads to 3.
  - Write ctrl=0x7: pending clears and `INT` falls next cycle, unless the timer expires that same cycle.
- Simultaneous clear and expiry: a clear-pending write that lands on the expiry edge leaves `irq_pending`=1.
- Unmapped address:
  - Read 0x8000_0000: `Data_to_cpu`=0 with `MIO_ready` after 1 cycle.
  - Write to the same address changes no register.
- Reset mid-read: assert `reset` in the RD_WAIT cycle. Outputs go to 0 immediately, no `MIO_ready` pulse occurs, and a fresh read after release completes normally.
